// File: rtl/hazard_ctl_pkg.sv
// Shared widths, state encoding and control-word layout for the LEGv8 pipeline sequencer.
package hazard_ctl_pkg;

  localparam int REGW = 5;
  localparam logic [REGW-1:0] XZR_REG = 5'd31;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MUL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_nop;
    logic idex_stall;
    logic idex_nop;
    logic exmem_nop;
  } hz_ctl_t;

  // Bit order: pc_stall, ifid_stall, ifid_nop, idex_stall, idex_nop, exmem_nop
  localparam hz_ctl_t CTL_IDLE  = hz_ctl_t'(6'b000000);
  localparam hz_ctl_t CTL_FLUSH = hz_ctl_t'(6'b001011);
  localparam hz_ctl_t CTL_MUL   = hz_ctl_t'(6'b110101);
  localparam hz_ctl_t CTL_LDUSE = hz_ctl_t'(6'b110010);

endpackage

// File: rtl/hazard_ctl_loaduse_det.sv
// Load-use comparator: flags when the ID instruction reads the register a load in EX is writing.
module loaduse_det
  import hazard_ctl_pkg::*;
#(
  parameter logic [REGW-1:0] XZR = XZR_REG
) (
  input  logic [REGW-1:0] i_id_rn,
  input  logic [REGW-1:0] i_id_rm,
  input  logic            i_id_usesrn,
  input  logic            i_id_usesrm,
  input  logic            i_ex_memread,
  input  logic [REGW-1:0] i_ex_rd,
  output logic            o_hit
);

  logic w_rn_match;
  logic w_rm_match;

  assign w_rn_match = i_id_usesrn && (i_id_rn == i_ex_rd);
  assign w_rm_match = i_id_usesrm && (i_id_rm == i_ex_rd);

  // A load targeting XZR discards its result, so nothing can depend on it.
  assign o_hit = i_ex_memread && (i_ex_rd != XZR) && (w_rn_match || w_rm_match);

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline sequencer: branch flush, multi-cycle MUL hold and load-use stall for the LEGv8 core,
// plus a saturating count of front-end stall cycles.
module hazard_ctl
  import hazard_ctl_pkg::*;
#(
  parameter int              MUL_LAT = 4,
  parameter int              CNTW    = 16,
  parameter logic [REGW-1:0] XZR     = XZR_REG
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [REGW-1:0] i_id_rn,
  input  logic [REGW-1:0] i_id_rm,
  input  logic            i_id_usesrn,
  input  logic            i_id_usesrm,
  input  logic            i_ex_memread,
  input  logic [REGW-1:0] i_ex_rd,
  input  logic            i_ex_mul,
  input  logic            i_mem_taken,
  output logic            o_pc_stall,
  output logic            o_ifid_stall,
  output logic            o_ifid_nop,
  output logic            o_idex_stall,
  output logic            o_idex_nop,
  output logic            o_exmem_nop,
  output logic [CNTW-1:0] o_stall_cycles
);

  localparam int CW = $clog2(MUL_LAT);
  localparam logic [CW-1:0] CNT_START = CW'(MUL_LAT - 2);

  hz_state_e       r_st;
  logic [CW-1:0]   r_cnt;
  logic [CNTW-1:0] r_stall_cycles;
  logic            w_lu_hit;
  hz_ctl_t         w_ctl;

  loaduse_det #(
    .XZR(XZR)
  ) u_loaduse_det (
    .i_id_rn     (i_id_rn),
    .i_id_rm     (i_id_rm),
    .i_id_usesrn (i_id_usesrn),
    .i_id_usesrm (i_id_usesrm),
    .i_ex_memread(i_ex_memread),
    .i_ex_rd     (i_ex_rd),
    .o_hit       (w_lu_hit)
  );

  // Priority: reset > flush > MUL sequencing > load-use > idle.
  always_comb begin
    w_ctl = CTL_IDLE;
    if (i_rst) begin
      w_ctl = CTL_FLUSH;
    end else if (i_mem_taken) begin
      w_ctl = CTL_FLUSH;
    end else if (r_st == ST_MUL) begin
      // cnt==0 is the release cycle; ex_mul still shows the same MUL and is ignored.
      if (r_cnt != '0) begin
        w_ctl = CTL_MUL;
      end
    end else if (i_ex_mul) begin
      w_ctl = CTL_MUL;
    end else if (w_lu_hit) begin
      w_ctl = CTL_LDUSE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st           <= ST_RUN;
      r_cnt          <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (i_mem_taken) begin
        r_st  <= ST_RUN;
        r_cnt <= '0;
      end else if (r_st == ST_MUL) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - CW'(1);
        end else begin
          r_st <= ST_RUN;
        end
      end else if (i_ex_mul) begin
        r_st  <= ST_MUL;
        r_cnt <= CNT_START;
      end

      if (w_ctl.pc_stall && (r_stall_cycles != {CNTW{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNTW'(1);
      end
    end
  end

  assign o_pc_stall     = w_ctl.pc_stall;
  assign o_ifid_stall   = w_ctl.ifid_stall;
  assign o_ifid_nop     = w_ctl.ifid_nop;
  assign o_idex_stall   = w_ctl.idex_stall;
  assign o_idex_nop     = w_ctl.idex_nop;
  assign o_exmem_nop    = w_ctl.exmem_nop;
  assign o_stall_cycles = r_stall_cycles;

endmodule
